// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle MULT/DIV sequencer that borrows the shared ALU for shift-add / restoring steps.
// Optional signed support (PRE/POST sign-fix stages) is built only when MULDIV_SIGNED_EN is defined.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [1:0]       alu_operation,
  output logic             alu_binvert,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE1  = 3'd1,
    S_PRE2  = 3'd2,
    S_ITER  = 3'd3,
    S_POST1 = 3'd4,
    S_POST2 = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] whi_r;   // product high half / partial remainder
  logic [WIDTH-1:0] wlo_r;   // multiplier shift reg / quotient
  logic             op_div_r;
  logic             dbz_pend_r;
`ifdef MULDIV_SIGNED_EN
  logic             sgn_r;
  logic             sa_r;
  logic             sb_r;
  logic             cy_r;
`else
  logic             unused_s;
  assign unused_s = op_signed;
`endif

  logic [WIDTH-1:0] r_shift_s;
  logic [WIDTH-1:0] iter_hi_s;
  logic [WIDTH-1:0] iter_lo_s;
  logic             div_ok_s;

  // ALU operand steering and next working-register values for one iteration
  always_comb begin
    alu_in1       = {WIDTH{1'b0}};
    alu_in2       = {WIDTH{1'b0}};
    alu_operation = 2'b10;
    alu_binvert   = 1'b0;
    alu_cin       = 1'b0;
    r_shift_s     = {whi_r[WIDTH-2:0], wlo_r[WIDTH-1]};
    div_ok_s      = alu_carry | whi_r[WIDTH-1];
    iter_hi_s     = whi_r;
    iter_lo_s     = wlo_r;
    case (state_r)
      S_ITER: begin
        if (op_div_r) begin
          alu_in1     = r_shift_s;
          alu_in2     = b_r;
          alu_binvert = 1'b1;
          alu_cin     = 1'b1;
          iter_hi_s   = div_ok_s ? alu_result : r_shift_s;
          iter_lo_s   = {wlo_r[WIDTH-2:0], div_ok_s};
        end else begin
          alu_in1   = whi_r;
          alu_in2   = a_r;
          iter_hi_s = wlo_r[0] ? {alu_carry, alu_result[WIDTH-1:1]} : {1'b0, whi_r[WIDTH-1:1]};
          iter_lo_s = wlo_r[0] ? {alu_result[0], wlo_r[WIDTH-1:1]} : {whi_r[0], wlo_r[WIDTH-1:1]};
        end
      end
`ifdef MULDIV_SIGNED_EN
      // Negations are 0 + ~x + cin through the shared adder
      S_PRE1: begin
        alu_in2     = a_r;
        alu_binvert = 1'b1;
        alu_cin     = 1'b1;
      end
      S_PRE2: begin
        alu_in2     = b_r;
        alu_binvert = 1'b1;
        alu_cin     = 1'b1;
      end
      S_POST1: begin
        alu_in2     = wlo_r;
        alu_binvert = 1'b1;
        alu_cin     = 1'b1;
      end
      S_POST2: begin
        alu_in2     = whi_r;
        alu_binvert = 1'b1;
        alu_cin     = op_div_r ? 1'b1 : cy_r;
      end
`endif
      default: begin
        alu_in1 = {WIDTH{1'b0}};
      end
    endcase
  end

  // Sequencer state, working registers and registered results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      whi_r       <= {WIDTH{1'b0}};
      wlo_r       <= {WIDTH{1'b0}};
      op_div_r    <= 1'b0;
      dbz_pend_r  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= {WIDTH{1'b0}};
      lo          <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sgn_r       <= 1'b0;
      sa_r        <= 1'b0;
      sb_r        <= 1'b0;
      cy_r        <= 1'b0;
`endif
    end else if (flush && (state_r != S_IDLE)) begin
      state_r <= S_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            a_r         <= src_a;
            b_r         <= src_b;
            op_div_r    <= op_div;
            whi_r       <= {WIDTH{1'b0}};
            wlo_r       <= op_div ? src_a : src_b;
            cnt_r       <= {CNT_W{1'b0}};
            dbz_pend_r  <= op_div && (src_b == {WIDTH{1'b0}});
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
`ifdef MULDIV_SIGNED_EN
            sgn_r       <= op_signed;
            sa_r        <= op_signed & src_a[WIDTH-1];
            sb_r        <= op_signed & src_b[WIDTH-1];
            state_r     <= op_signed ? S_PRE1 : S_ITER;
`else
            state_r     <= S_ITER;
`endif
          end
        end
        S_ITER: begin
          whi_r <= iter_hi_s;
          wlo_r <= iter_lo_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            cnt_r <= {CNT_W{1'b0}};
`ifdef MULDIV_SIGNED_EN
            if (sgn_r) begin
              state_r <= S_POST1;
            end else begin
              hi          <= iter_hi_s;
              lo          <= iter_lo_s;
              div_by_zero <= dbz_pend_r;
              done        <= 1'b1;
              busy        <= 1'b0;
              state_r     <= S_DONE;
            end
`else
            hi          <= iter_hi_s;
            lo          <= iter_lo_s;
            div_by_zero <= dbz_pend_r;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_r     <= S_DONE;
`endif
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_PRE1: begin
          if (sa_r) a_r <= alu_result;
          state_r <= S_PRE2;
        end
        S_PRE2: begin
          if (sb_r) b_r <= alu_result;
          wlo_r   <= op_div_r ? a_r : (sb_r ? alu_result : b_r);
          state_r <= S_ITER;
        end
        // A zero divisor leaves the all-ones quotient and remainder uncorrected
        S_POST1: begin
          if ((sa_r ^ sb_r) && !dbz_pend_r) wlo_r <= alu_result;
          cy_r    <= alu_carry;
          state_r <= S_POST2;
        end
        S_POST2: begin
          hi          <= (op_div_r ? (sa_r && !dbz_pend_r) : (sa_r ^ sb_r)) ? alu_result : whi_r;
          lo          <= wlo_r;
          div_by_zero <= dbz_pend_r;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= S_DONE;
        end
`endif
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
